aes_state_bank: RTL and testbench
=================================

# aes_state_bank

Multi-context AES state storage: holds up to NUM_CTX independent in-flight AES states, each with its own round counter and lifecycle (IDLE/BUSY/DONE). It lets one round datapath interleave several blocks. It sits between the block input interface, the round datapath (read/update port) and the ciphertext output interface, and replaces the single-state register in multi-block configurations.

## Interface
- DATA_W, 128, state width in bits
- NUM_CTX, 4, number of contexts (2..16)
- CTX_W, $clog2(NUM_CTX), context index width
- NUM_ROUNDS, 10, updates per block before DONE (10/12/14)
- ROUND_W, 4, round counter width; must hold NUM_ROUNDS
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  new block offered
- in_ready  output  1  context in_ctx is IDLE
- in_ctx  input  CTX_W  target context for load
- in_data  input  DATA_W  initial state (plaintext ^ key0)
- upd_en  input  1  round result write
- upd_ctx  input  CTX_W  context being updated
- upd_data  input  DATA_W  next state
- upd_err  output  1  registered pulse: upd_en hit a non-BUSY context
- rd_ctx  input  CTX_W  read-port select
- rd_data  output  DATA_W  state of rd_ctx (combinational from registers)
- rd_round  output  ROUND_W  round counter of rd_ctx
- out_valid  output  1  a DONE context is presented
- out_ready  input  1  consumer accepts
- out_ctx  output  CTX_W  presented context
- out_data  output  DATA_W  presented final state

## Operation
- Per context: state[DATA_W], round[ROUND_W], status ∈ {IDLE, BUSY, DONE}.
- Load: in_valid && in_ready at edge -> state=in_data, round=0, status=BUSY.
- Update: upd_en && status[upd_ctx]==BUSY -> state=upd_data, round+=1. If the new round == NUM_ROUNDS, status=DONE.
- upd_en to an IDLE/DONE context: ignored, no state change; upd_err=1 the next cycle.
- Load and update can never target one context in the same cycle, because they require IDLE and BUSY respectively. Load and update to different contexts in the same cycle both take effect.
- Output stage: registered sel_q/out_valid_q. When out_valid_q==0, or a handshake occurs, pick the first DONE context at or after rr_ptr (wrapping modulo NUM_CTX). Exclude the context being unloaded this cycle.
- On a pick: out_valid_q=1, sel_q=pick, rr_ptr=pick+1 (wraps NUM_CTX-1 -> 0). With no candidate: out_valid_q=0.
- out_ctx=sel_q and out_data=state[sel_q]. Both stay stable while out_valid && !out_ready; a DONE state is immutable.
- Handshake (out_valid && out_ready): status[sel_q]=IDLE, round=0.
- A context unloaded at edge t can accept a load from edge t+1.
- Reset (rst_n low at edge) clears everything to zero/IDLE, including mid-round or mid-presentation contexts. All outputs are 0 after reset; in_ready follows status, so it is 1 after reset.

## Timing
- in_ready: combinational from status[in_ctx]; no dependency on in_valid.
- Load latency: 1 cycle; rd_data shows in_data the cycle after acceptance.
- DONE at edge t -> out_valid at edge t+1 (earliest) -> accept at t+1 or later.
- Back-to-back unload: with ≥2 DONE contexts and out_ready held 1, one context leaves per cycle.
- upd_err: 1 cycle after the offending upd_en; 1 cycle wide per event.
- Block throughput per context: 1 load + NUM_ROUNDS updates + 1 unload.

## Configuration
- AES_STATE_BANK_SCRUB_EN defined: on handshake, state[sel_q] is cleared to 0 in the same edge as the IDLE transition. On reset-free idle, rd_data of a freed context reads 0.
- Not defined: state of a freed context keeps its last value until the next load. Saves DATA_W×NUM_CTX clear muxes.

## Structure
- Shared package aes_pkg: status enum (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), default NUM_ROUNDS constants (AES128/192/256 = 10/12/14).
- One sub-module: aes_rr_pick (NUM_CTX request vector + start pointer -> grant index, any-valid), purely combinational.
- Context storage is flat arrays inside aes_state_bank; no per-context instance.

## Test plan
- Reset: drive garbage, rst_n=0 one edge -> all rd_round=0, out_valid=0, upd_err=0, in_ready=1 for every ctx.
- Single block, ctx 2: load 0x00112233..., 10 updates with data=round index -> DONE after the 10th. out_valid 1 cycle later with out_ctx=2 and the 10th value. Ready -> ctx 2 IDLE.
- Interleave 4 contexts, round-robin updates -> all finish on consecutive cycles. With out_ready=1, out_ctx sequence 0,1,2,3 at 1/cycle. rr_ptr wraps to 0.
- Backpressure: out_ready=0 for 5 cycles while ctx 1 DONE and ctx 3 becomes DONE -> out_ctx/out_data stay at ctx 1. Release -> ctx 1, then ctx 3.
- Illegal update to IDLE ctx 0 -> upd_err=1 next cycle only, rd_data of ctx 0 unchanged. Load to BUSY ctx -> in_ready=0, no change.
- Reset asserted mid-round (ctx 1 at round 5, ctx 0 presented) -> all IDLE, out_valid=0 next cycle. With AES_STATE_BANK_SCRUB_EN: after unload, rd_data of that ctx = 0.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared types and constants for the AES multi-context state
//               bank: per-context lifecycle status and standard round counts.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

   // Per-context lifecycle: loaded -> rounds in progress -> awaiting unload
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } ctx_status_e;

   // Number of round updates per block for each AES key size
   localparam int AES128_ROUNDS = 10;
   localparam int AES192_ROUNDS = 12;
   localparam int AES256_ROUNDS = 14;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : aes_rr_pick
// Description : Combinational round-robin picker. Returns the index of the
//               first asserted request at or after the start pointer,
//               wrapping modulo NUM_CTX, plus an any-request flag.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_rr_pick #(
   parameter int NUM_CTX = 4,
   parameter int CTX_W   = $clog2(NUM_CTX)
) (
   input  logic [NUM_CTX-1:0] req,
   input  logic [CTX_W-1:0]   start,
   output logic [CTX_W-1:0]   grant,
   output logic               any
);

   // Scan from the farthest offset down so the nearest request wins last
   always_comb begin
      logic [CTX_W:0]   sum;
      logic [CTX_W-1:0] idx;
      sum   = '0;
      idx   = '0;
      grant = '0;
      any   = 1'b0;
      for (int i = NUM_CTX - 1; i >= 0; i--) begin
         sum = {1'b0, start} + (CTX_W+1)'(i);
         if (sum >= (CTX_W+1)'(NUM_CTX)) begin
            sum = sum - (CTX_W+1)'(NUM_CTX);
         end
         idx = sum[CTX_W-1:0];
         if (req[idx]) begin
            grant = idx;
            any   = 1'b1;
         end
      end
   end

endmodule : aes_rr_pick
`default_nettype wire

// File: rtl/aes_state_bank.sv
`default_nettype none
// ============================================================================
// Module      : aes_state_bank
// Description : Multi-context AES state storage. Holds NUM_CTX independent
//               in-flight states, each with a round counter and an
//               IDLE/BUSY/DONE lifecycle, so one round datapath can
//               interleave several blocks. Finished contexts are presented
//               round-robin on a valid/ready output port.
// Options     : AES_STATE_BANK_SCRUB_EN - clear a context's state on unload.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_state_bank
   import aes_pkg::*;
#(
   parameter int DATA_W     = 128,
   parameter int NUM_CTX    = 4,
   parameter int CTX_W      = $clog2(NUM_CTX),
   parameter int NUM_ROUNDS = AES128_ROUNDS,
   parameter int ROUND_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   // block input
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CTX_W-1:0]   in_ctx,
   input  logic [DATA_W-1:0]  in_data,
   // round datapath update port
   input  logic               upd_en,
   input  logic [CTX_W-1:0]   upd_ctx,
   input  logic [DATA_W-1:0]  upd_data,
   output logic               upd_err,
   // round datapath read port
   input  logic [CTX_W-1:0]   rd_ctx,
   output logic [DATA_W-1:0]  rd_data,
   output logic [ROUND_W-1:0] rd_round,
   // ciphertext output
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CTX_W-1:0]   out_ctx,
   output logic [DATA_W-1:0]  out_data
);

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);
   localparam logic [CTX_W-1:0]   LAST_CTX   = CTX_W'(NUM_CTX - 1);

   logic [DATA_W-1:0]  state_q  [NUM_CTX];
   logic [DATA_W-1:0]  state_d  [NUM_CTX];
   logic [ROUND_W-1:0] round_q  [NUM_CTX];
   logic [ROUND_W-1:0] round_d  [NUM_CTX];
   ctx_status_e        status_q [NUM_CTX];
   ctx_status_e        status_d [NUM_CTX];

   logic [CTX_W-1:0]   sel_q, sel_d;
   logic [CTX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               out_valid_q, out_valid_d;
   logic               upd_err_q, upd_err_d;

   logic               load_fire;
   logic               upd_hit;
   logic               unload_fire;
   logic [NUM_CTX-1:0] done_req;
   logic [CTX_W-1:0]   pick;
   logic               pick_any;

   assign in_ready    = (status_q[in_ctx] == IDLE);
   assign load_fire   = in_valid && in_ready;
   assign upd_hit     = upd_en && (status_q[upd_ctx] == BUSY);
   assign unload_fire = out_valid_q && out_ready;

   assign rd_data   = state_q[rd_ctx];
   assign rd_round  = round_q[rd_ctx];
   assign out_valid = out_valid_q;
   assign out_ctx   = sel_q;
   assign out_data  = state_q[sel_q];
   assign upd_err   = upd_err_q;

   // A context leaving on this edge must not be re-presented
   generate
      for (genvar gi = 0; gi < NUM_CTX; gi++) begin : g_done_req
         assign done_req[gi] = (status_q[gi] == DONE) &&
                               !(unload_fire && (sel_q == CTX_W'(gi)));
      end
   endgenerate

   aes_rr_pick #(
      .NUM_CTX (NUM_CTX),
      .CTX_W   (CTX_W)
   ) u_rr_pick (
      .req   (done_req),
      .start (rr_ptr_q),
      .grant (pick),
      .any   (pick_any)
   );

   // Per-context next state: load, round update and unload never collide
   // on one context because they need IDLE, BUSY and DONE respectively
   always_comb begin
      logic [ROUND_W-1:0] next_round;
      next_round = '0;
      state_d    = state_q;
      round_d    = round_q;
      status_d   = status_q;
      for (int i = 0; i < NUM_CTX; i++) begin
         if (load_fire && (in_ctx == CTX_W'(i))) begin
            state_d[i]  = in_data;
            round_d[i]  = '0;
            status_d[i] = BUSY;
         end
         if (upd_hit && (upd_ctx == CTX_W'(i))) begin
            next_round  = round_q[i] + 1'b1;
            state_d[i]  = upd_data;
            round_d[i]  = next_round;
            if (next_round == LAST_ROUND) begin
               status_d[i] = DONE;
            end
         end
         if (unload_fire && (sel_q == CTX_W'(i))) begin
            status_d[i] = IDLE;
            round_d[i]  = '0;
`ifdef AES_STATE_BANK_SCRUB_EN
            state_d[i]  = '0;
`endif
         end
      end
   end

   // Output selection: re-pick when nothing is held or the held one leaves
   always_comb begin
      sel_d       = sel_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      upd_err_d   = upd_en && (status_q[upd_ctx] != BUSY);
      if (!out_valid_q || unload_fire) begin
         out_valid_d = pick_any;
         if (pick_any) begin
            sel_d    = pick;
            rr_ptr_d = (pick == LAST_CTX) ? '0 : pick + 1'b1;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CTX; i++) begin
            state_q[i]  <= '0;
            round_q[i]  <= '0;
            status_q[i] <= IDLE;
         end
         sel_q       <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         upd_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         status_q    <= status_d;
         sel_q       <= sel_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         upd_err_q   <= upd_err_d;
      end
   end

endmodule : aes_state_bank
`default_nettype wire

// File: tb/tb_aes_state_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_state_bank
// Description : Directed self-checking bench for aes_state_bank: reset,
//               single block, interleaved contexts, backpressure, illegal
//               accesses and mid-round reset.
// Options     : AES_STATE_BANK_SCRUB_EN - changes freed-context expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_state_bank;

   localparam int DATA_W  = 128;
   localparam int NUM_CTX = 4;
   localparam int CTX_W   = 2;
   localparam int ROUND_W = 4;
`ifdef AES_STATE_BANK_SCRUB_EN
   localparam bit SCRUB = 1'b1;
`else
   localparam bit SCRUB = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [CTX_W-1:0]   in_ctx;
   logic [DATA_W-1:0]  in_data;
   logic               upd_en;
   logic [CTX_W-1:0]   upd_ctx;
   logic [DATA_W-1:0]  upd_data;
   logic               upd_err;
   logic [CTX_W-1:0]   rd_ctx;
   logic [DATA_W-1:0]  rd_data;
   logic [ROUND_W-1:0] rd_round;
   logic               out_valid;
   logic               out_ready;
   logic [CTX_W-1:0]   out_ctx;
   logic [DATA_W-1:0]  out_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   aes_state_bank u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctx    (in_ctx),
      .in_data   (in_data),
      .upd_en    (upd_en),
      .upd_ctx   (upd_ctx),
      .upd_data  (upd_data),
      .upd_err   (upd_err),
      .rd_ctx    (rd_ctx),
      .rd_data   (rd_data),
      .rd_round  (rd_round),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctx   (out_ctx),
      .out_data  (out_data)
   );

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input int c);
      rd_ctx = CTX_W'(c);
      in_ctx = CTX_W'(c);
      #1;
   endtask

   initial begin
      logic [DATA_W-1:0] key_blk;
      key_blk = 128'h00112233445566778899aabbccddeeff;

      // ---------------- reset with garbage on the inputs ----------------
      rst_n = 1'b0; in_valid = 1'b1; in_ctx = 2'd1; in_data = '1;
      upd_en = 1'b1; upd_ctx = 2'd3; upd_data = '1; out_ready = 1'b1; rd_ctx = 2'd0;
      tick;
      rst_n = 1'b1; in_valid = 1'b0; in_ctx = '0; in_data = '0;
      upd_en = 1'b0; upd_ctx = '0; upd_data = '0; out_ready = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_upd_err", upd_err, 0);
      chk("rst_out_ctx", out_ctx, 0);
      chk("rst_out_data", out_data, 0);
      for (int c = 0; c < NUM_CTX; c++) begin
         peek(c);
         chk($sformatf("rst_round_%0d", c), rd_round, 0);
         chk($sformatf("rst_in_ready_%0d", c), in_ready, 1);
         chk($sformatf("rst_rd_data_%0d", c), rd_data, 0);
      end

      // ---------------- single block on ctx 2 ----------------
      in_valid = 1'b1; in_ctx = 2'd2; in_data = key_blk; #1;
      chk("s_in_ready_pre", in_ready, 1);
      tick;
      in_valid = 1'b0;
      peek(2);
      chk("s_load_data", rd_data, key_blk);
      chk("s_load_round", rd_round, 0);
      chk("s_busy_not_ready", in_ready, 0);
      for (int r = 1; r <= 10; r++) begin
         upd_en = 1'b1; upd_ctx = 2'd2; upd_data = DATA_W'(r);
         tick;
         chk($sformatf("s_round_%0d", r), rd_round, r);
         chk($sformatf("s_no_out_%0d", r), out_valid, 0);
      end
      upd_en = 1'b0;
      tick;
      chk("s_out_valid", out_valid, 1);
      chk("s_out_ctx", out_ctx, 2);
      chk("s_out_data", out_data, 10);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("s_out_gone", out_valid, 0);
      peek(2);
      chk("s_freed_ready", in_ready, 1);
      chk("s_freed_round", rd_round, 0);
      chk("s_freed_data", rd_data, SCRUB ? 0 : 10);

      // ---------------- four interleaved contexts ----------------
      for (int c = 0; c < NUM_CTX; c++) begin
         in_valid = 1'b1; in_ctx = CTX_W'(c); in_data = DATA_W'(32'hA0 + c);
         tick;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int r = 1; r <= 10; r++) begin
         for (int c = 0; c < NUM_CTX; c++) begin
            upd_en = 1'b1; upd_ctx = CTX_W'(c); upd_data = DATA_W'(c * 256 + r);
            tick;
            if (r == 10 && c == 0) begin
               chk("i_not_yet", out_valid, 0);
            end else if (r == 10) begin
               chk($sformatf("i_valid_%0d", c - 1), out_valid, 1);
               chk($sformatf("i_ctx_%0d", c - 1), out_ctx, c - 1);
               chk($sformatf("i_data_%0d", c - 1), out_data, (c - 1) * 256 + 10);
            end
         end
      end
      upd_en = 1'b0;
      tick;
      chk("i_valid_3", out_valid, 1);
      chk("i_ctx_3", out_ctx, 3);
      chk("i_data_3", out_data, 32'h30a);
      tick;
      chk("i_drained", out_valid, 0);
      out_ready = 1'b0;
      for (int c = 0; c < NUM_CTX; c++) begin
         peek(c);
         chk($sformatf("i_idle_%0d", c), in_ready, 1);
      end

      // ---------------- backpressure ----------------
      in_valid = 1'b1; in_ctx = 2'd1; in_data = DATA_W'(32'h1000);
      tick;
      in_ctx = 2'd3; in_data = DATA_W'(32'h3000);
      tick;
      in_valid = 1'b0;
      for (int r = 1; r <= 10; r++) begin
         upd_en = 1'b1; upd_ctx = 2'd1; upd_data = DATA_W'(32'h1100 + r);
         tick;
      end
      for (int r = 1; r <= 10; r++) begin
         upd_en = 1'b1; upd_ctx = 2'd3; upd_data = DATA_W'(32'h3300 + r);
         tick;
         if (r == 1) begin
            chk("b_first_valid", out_valid, 1);
            chk("b_first_ctx", out_ctx, 1);
         end
      end
      upd_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("b_hold_valid_%0d", k), out_valid, 1);
         chk($sformatf("b_hold_ctx_%0d", k), out_ctx, 1);
         chk($sformatf("b_hold_data_%0d", k), out_data, 32'h110a);
         tick;
      end
      out_ready = 1'b1;
      chk("b_rel_ctx1", out_ctx, 1);
      tick;
      chk("b_next_valid", out_valid, 1);
      chk("b_next_ctx", out_ctx, 3);
      chk("b_next_data", out_data, 32'h330a);
      tick;
      chk("b_drained", out_valid, 0);
      out_ready = 1'b0;

      // ---------------- illegal update and blocked load ----------------
      peek(0);
      upd_en = 1'b1; upd_ctx = 2'd0; upd_data = DATA_W'(32'hdead);
      chk("e_err_before", upd_err, 0);
      tick;
      upd_en = 1'b0;
      chk("e_err_pulse", upd_err, 1);
      chk("e_data_kept", rd_data, SCRUB ? 0 : 32'h0a);
      chk("e_round_kept", rd_round, 0);
      tick;
      chk("e_err_clear", upd_err, 0);
      in_valid = 1'b1; in_ctx = 2'd2; in_data = DATA_W'(32'h2222);
      tick;
      in_data = DATA_W'(32'hbeef); #1;
      chk("e_busy_not_ready", in_ready, 0);
      tick;
      in_valid = 1'b0;
      peek(2);
      chk("e_busy_data", rd_data, 32'h2222);
      chk("e_busy_round", rd_round, 0);
      // load ctx 0 while updating ctx 2 on the same edge
      in_valid = 1'b1; in_ctx = 2'd0; in_data = DATA_W'(32'h0f0f);
      upd_en = 1'b1; upd_ctx = 2'd2; upd_data = DATA_W'(32'h2201);
      tick;
      in_valid = 1'b0; upd_en = 1'b0;
      chk("e_dual_no_err", upd_err, 0);
      peek(0);
      chk("e_dual_load_data", rd_data, 32'h0f0f);
      chk("e_dual_load_ready", in_ready, 0);
      peek(2);
      chk("e_dual_upd_data", rd_data, 32'h2201);
      chk("e_dual_upd_round", rd_round, 1);

      // ---------------- reset mid-round / mid-presentation ----------------
      in_valid = 1'b1; in_ctx = 2'd1; in_data = DATA_W'(32'h1111);
      tick;
      in_valid = 1'b0;
      for (int r = 1; r <= 10; r++) begin
         upd_en = 1'b1; upd_ctx = 2'd0; upd_data = DATA_W'(32'h0e00 + r);
         tick;
      end
      for (int r = 1; r <= 5; r++) begin
         upd_en = 1'b1; upd_ctx = 2'd1; upd_data = DATA_W'(32'h1200 + r);
         tick;
      end
      upd_en = 1'b0;
      chk("m_pres_valid", out_valid, 1);
      chk("m_pres_ctx", out_ctx, 0);
      chk("m_pres_data", out_data, 32'h0e0a);
      peek(1);
      chk("m_ctx1_round", rd_round, 5);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("m_out_valid", out_valid, 0);
      chk("m_out_data", out_data, 0);
      chk("m_upd_err", upd_err, 0);
      for (int c = 0; c < NUM_CTX; c++) begin
         peek(c);
         chk($sformatf("m_round_%0d", c), rd_round, 0);
         chk($sformatf("m_ready_%0d", c), in_ready, 1);
         chk($sformatf("m_data_%0d", c), rd_data, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_aes_state_bank
`default_nettype wire
